// File: rtl/cpu_defs.sv
// Shared encodings for the MIPS core pipeline: writeback source select,
// load-type codes and GPR addressing constants.
// No ports; imported by the MEM/WB stage and its load extractor.
package cpu_defs;

  localparam int GPR_AW = 5;
  localparam logic [GPR_AW-1:0] ZERO_REG = '0;

  // 2'b11 also selects the ALU result.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ALU2 = 2'b11
  } wb_src_e;

  // Codes 3'b101..3'b111 are unused and behave as LD_W.
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  // One WB pipeline slot. The full raw memory word is kept so that lane
  // extraction happens after the register, off the MEM-stage path.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [GPR_AW-1:0] dst;
    logic [1:0]        wb_src;
    logic [2:0]        load_type;
    logic [31:0]       alu_result;
    logic [31:0]       read_data;
    logic [31:0]       link_pc;
  } wb_reg_t;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Purpose: pick the byte/halfword lane of a loaded word and sign/zero-extend it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: word (raw 32-bit memory word), off (byte offset), load_type
//        (LD_* code), data (extended result).
module load_extract
  import cpu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // Little-endian lanes: offset 0 is the least significant byte.
    byte_lane = word[7:0];
    case (off)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    // off[0] is deliberately ignored for halfword loads.
    half_lane = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (load_type)
      LD_B:    data = {{24{byte_lane[7]}}, byte_lane};
      LD_BU:   data = {24'h0, byte_lane};
      LD_H:    data = {{16{half_lane[15]}}, half_lane};
      LD_HU:   data = {16'h0, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose: MEM/WB pipeline register, writeback select and retired-instruction counter.
// Latency: one cycle from Mem* inputs to RegWrite* outputs; outputs are combinational from the register.
// Backpressure: Stall holds the WB slot; Flush inserts a bubble and overrides Stall.
// Ports: clk/rst (sync active-high), Stall, Flush, Mem* (MEM-stage results),
//        RegWriteData/RegWriteAddr/RegWriteEn (register file write port),
//        WbValid (WB slot occupied), RetireCount (instructions leaving WB).
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              MemValid,
  input  logic              MemRegWrite,
  input  logic [GPR_AW-1:0] MemDstAddr,
  input  logic [1:0]        MemWbSrc,
  input  logic [2:0]        MemLoadType,
  input  logic [DW-1:0]     MemAluResult,
  input  logic [DW-1:0]     MemReadData,
  input  logic [DW-1:0]     MemLinkPC,
  output logic [DW-1:0]     RegWriteData,
  output logic [GPR_AW-1:0] RegWriteAddr,
  output logic              RegWriteEn,
  output logic              WbValid,
  output logic [CW-1:0]     RetireCount
);

  wb_reg_t       wb_q;
  logic [CW-1:0] retire_q;
  logic [DW-1:0] load_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      retire_q <= '0;
    end else begin
      // The occupant leaves WB whenever the slot is not held; a flush
      // replaces it too, so it still retires even under a stall.
      if (wb_q.valid && (Flush || !Stall)) begin
        retire_q <= retire_q + CW'(1);
      end
      if (Flush) begin
        wb_q.valid     <= 1'b0;
        wb_q.reg_write <= 1'b0;
      end else if (!Stall) begin
        wb_q <= '{
          valid:      MemValid,
          reg_write:  MemRegWrite,
          dst:        MemDstAddr,
          wb_src:     MemWbSrc,
          load_type:  MemLoadType,
          alu_result: MemAluResult,
          read_data:  MemReadData,
          link_pc:    MemLinkPC
        };
      end
    end
  end

  // Byte offset comes from the latched effective address.
  load_extract u_load_extract (
    .word      (wb_q.read_data),
    .off       (wb_q.alu_result[1:0]),
    .load_type (wb_q.load_type),
    .data      (load_data)
  );

  always_comb begin
    RegWriteData = wb_q.alu_result;
    case (wb_q.wb_src)
      WB_MEM:  RegWriteData = load_data;
      WB_LINK: RegWriteData = wb_q.link_pc;
      default: RegWriteData = wb_q.alu_result;
    endcase
  end

  // $0 is hardwired to zero, so a write to it is never issued.
  assign RegWriteEn   = wb_q.valid & wb_q.reg_write & (wb_q.dst != ZERO_REG);
  assign RegWriteAddr = wb_q.dst;
  assign WbValid      = wb_q.valid;
  assign RetireCount  = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, Stall, Flush, MemValid, MemRegWrite;
  logic [4:0]  MemDstAddr;
  logic [1:0]  MemWbSrc;
  logic [2:0]  MemLoadType;
  logic [31:0] MemAluResult, MemReadData, MemLinkPC;

  logic [31:0] RegWriteData, RegWriteData4;
  logic [4:0]  RegWriteAddr, RegWriteAddr4;
  logic        RegWriteEn, RegWriteEn4, WbValid, WbValid4;
  logic [31:0] RetireCount;
  logic [3:0]  RetireCount4;

  always #5 clk = ~clk;

  mem_wb_stage #(.DW(32), .CW(32)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemDstAddr(MemDstAddr),
    .MemWbSrc(MemWbSrc), .MemLoadType(MemLoadType), .MemAluResult(MemAluResult),
    .MemReadData(MemReadData), .MemLinkPC(MemLinkPC),
    .RegWriteData(RegWriteData), .RegWriteAddr(RegWriteAddr), .RegWriteEn(RegWriteEn),
    .WbValid(WbValid), .RetireCount(RetireCount)
  );

  mem_wb_stage #(.DW(32), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemDstAddr(MemDstAddr),
    .MemWbSrc(MemWbSrc), .MemLoadType(MemLoadType), .MemAluResult(MemAluResult),
    .MemReadData(MemReadData), .MemLinkPC(MemLinkPC),
    .RegWriteData(RegWriteData4), .RegWriteAddr(RegWriteAddr4), .RegWriteEn(RegWriteEn4),
    .WbValid(WbValid4), .RetireCount(RetireCount4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: contents of the WB slot plus the number of instructions
  // that have left it since reset.
  bit          m_valid, m_rw;
  bit [4:0]    m_dst;
  bit [1:0]    m_src;
  bit [2:0]    m_lt;
  bit [31:0]   m_alu, m_rd, m_link;
  longint unsigned m_cnt;

  function automatic bit [31:0] ref_data();
    bit [31:0] off, b, h, r;
    if (m_src == 2'd2) return m_link;
    if (m_src != 2'd1) return m_alu;
    off = m_alu % 4;
    b = (m_rd >> (8 * off)) % 256;
    h = (off >= 2) ? (m_rd >> 16) : (m_rd % 65536);
    case (m_lt)
      3'd1: r = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2: r = b;
      3'd3: r = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4: r = h;
      default: r = m_rd;
    endcase
    return r;
  endfunction

  task automatic check_outputs();
    bit exp_en;
    bit [31:0] exp_data;
    exp_en = m_valid && m_rw && (m_dst != 5'd0);
    exp_data = ref_data();
    chk("wb_valid", WbValid, m_valid);
    chk("wr_en", RegWriteEn, exp_en);
    chk("wr_en_cw4", RegWriteEn4, exp_en);
    chk("retire", RetireCount, m_cnt[31:0]);
    chk("retire_cw4", RetireCount4, m_cnt % 16);
    if (m_valid) begin
      chk("wr_addr", RegWriteAddr, m_dst);
      chk("wr_data", RegWriteData, exp_data);
      chk("wr_data_cw4", RegWriteData4, exp_data);
      chk("wr_addr_cw4", RegWriteAddr4, m_dst);
      chk("wb_valid_cw4", WbValid4, m_valid);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit v, input bit w,
                      input bit [4:0] d, input bit [1:0] src, input bit [2:0] lt,
                      input bit [31:0] alu, input bit [31:0] rdat, input bit [31:0] link);
    rst = r; Stall = s; Flush = f; MemValid = v; MemRegWrite = w;
    MemDstAddr = d; MemWbSrc = src; MemLoadType = lt;
    MemAluResult = alu; MemReadData = rdat; MemLinkPC = link;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_rw = 0; m_dst = 0; m_src = 0; m_lt = 0;
      m_alu = 0; m_rd = 0; m_link = 0; m_cnt = 0;
    end else if (f || !s) begin
      if (m_valid) m_cnt++;
      if (f) begin
        m_valid = 0; m_rw = 0;
      end else begin
        m_valid = v; m_rw = w; m_dst = d; m_src = src; m_lt = lt;
        m_alu = alu; m_rd = rdat; m_link = link;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic bubble();
    step(0, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  localparam bit [31:0] LDW = 32'h80FF_7F01;

  initial begin
    // Reset with active-looking inputs.
    step(1, 0, 0, 1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD_BEEF, LDW, 32'h44);
    step(1, 0, 0, 1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD_BEEF, LDW, 32'h44);
    chk("rst_data", RegWriteData, 32'h0);
    chk("rst_retire", RetireCount, 32'h0);

    // ALU writeback.
    step(0, 0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
    chk("alu_data", RegWriteData, 32'h0000_1234);
    chk("alu_addr", RegWriteAddr, 32'd5);

    // Sub-word loads, each checked against a hand-derived constant.
    step(0, 0, 0, 1, 1, 5'd6, 2'd1, 3'd1, 32'h1000_0003, LDW, 32'h0);
    chk("lb_off3", RegWriteData, 32'hFFFF_FF80);
    step(0, 0, 0, 1, 1, 5'd6, 2'd1, 3'd2, 32'h1000_0002, LDW, 32'h0);
    chk("lbu_off2", RegWriteData, 32'h0000_00FF);
    step(0, 0, 0, 1, 1, 5'd6, 2'd1, 3'd3, 32'h1000_0002, LDW, 32'h0);
    chk("lh_off2", RegWriteData, 32'hFFFF_80FF);
    step(0, 0, 0, 1, 1, 5'd6, 2'd1, 3'd4, 32'h1000_0000, LDW, 32'h0);
    chk("lhu_off0", RegWriteData, 32'h0000_7F01);
    step(0, 0, 0, 1, 1, 5'd6, 2'd1, 3'd0, 32'h1000_0003, LDW, 32'h0);
    chk("lw", RegWriteData, LDW);

    // $0 suppression, then link writeback.
    step(0, 0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'h5555_5555, 32'h0, 32'h0);
    chk("zero_reg_en", RegWriteEn, 32'd0);
    step(0, 0, 0, 1, 1, 5'd31, 2'd2, 3'd0, 32'h1, 32'h0, 32'h0040_0008);
    chk("link_data", RegWriteData, 32'h0040_0008);
    chk("link_en", RegWriteEn, 32'd1);

    // Instruction A held by three stall cycles, then released.
    step(0, 0, 0, 1, 1, 5'd7, 2'd0, 3'd0, 32'h0000_A5A5, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 1, 5'd8, 2'd2, 3'd0, 32'h1111_0000 + i, 32'h0, 32'h2222);
    chk("stall_hold_data", RegWriteData, 32'h0000_A5A5);
    bubble();

    // Stall and Flush together: Flush wins.
    step(0, 0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h0000_0033, 32'h0, 32'h0);
    step(0, 1, 1, 1, 1, 5'd4, 2'd0, 3'd0, 32'h0000_0044, 32'h0, 32'h0);
    chk("flush_en", RegWriteEn, 32'd0);
    chk("flush_valid", WbValid, 32'd0);

    // Reset mid-operation drops the pending write.
    step(0, 0, 0, 1, 1, 5'd12, 2'd0, 3'd0, 32'h0000_0C0C, 32'h0, 32'h0);
    step(1, 0, 0, 1, 1, 5'd13, 2'd0, 3'd0, 32'h0000_0D0D, 32'h0, 32'h0);
    chk("midrst_en", RegWriteEn, 32'd0);

    // Counter wrap on the 4-bit instance: 17 retirements leave it at 1.
    step(1, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 17; i++)
      step(0, 0, 0, 1, 1, 5'(i + 1), 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
    bubble();
    chk("wrap_cw4", RetireCount4, 32'd1);
    chk("wrap_cw32", RetireCount, 32'd17);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
